// File: rtl/exception_result_resolver_if.sv
// Bus bundle for exception_result_resolver: descriptor, datapath and result channels.
// EXC_RESOLVER_STATUS_EN adds the out_flag / exc_count status signals.
interface exception_result_resolver_if #(
  parameter int WIDTH = 32
);
  logic             exc_valid;
  logic             exc_ready;
  logic [2:0]       exception_flag;
  logic [WIDTH-2:0] copied_operand;
  logic             a_sign;
  logic             b_sign;
  logic             operation_select;
  logic             path_valid;
  logic             path_ready;
  logic [WIDTH-1:0] path_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             proto_err;
`ifdef EXC_RESOLVER_STATUS_EN
  logic [2:0]       out_flag;
  logic [15:0]      exc_count;

  modport slave (
    input  exc_valid, exception_flag, copied_operand, a_sign, b_sign, operation_select,
    input  path_valid, path_result, out_ready,
    output exc_ready, path_ready, out_valid, out_result, proto_err, out_flag, exc_count
  );
  modport master (
    output exc_valid, exception_flag, copied_operand, a_sign, b_sign, operation_select,
    output path_valid, path_result, out_ready,
    input  exc_ready, path_ready, out_valid, out_result, proto_err, out_flag, exc_count
  );
`else
  modport slave (
    input  exc_valid, exception_flag, copied_operand, a_sign, b_sign, operation_select,
    input  path_valid, path_result, out_ready,
    output exc_ready, path_ready, out_valid, out_result, proto_err
  );
  modport master (
    output exc_valid, exception_flag, copied_operand, a_sign, b_sign, operation_select,
    output path_valid, path_result, out_ready,
    input  exc_ready, path_ready, out_valid, out_result, proto_err
  );
`endif
endinterface

// File: rtl/exception_result_resolver.sv
// Queues classified FP add/sub exceptions and merges them with in-order datapath results.
// Optional status outputs (out_flag, exc_count) are enabled by EXC_RESOLVER_STATUS_EN.
module exception_result_resolver #(
  parameter int WIDTH     = 32,
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  exception_result_resolver_if.slave  bus
);
  // Handshakes: a transfer happens on a channel in every cycle where its valid and
  // ready are both high; valid never waits on ready, and out_* holds until accepted.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] FLAG_NONE          = 3'b000;
  localparam logic [2:0] FLAG_NAN           = 3'b001;
  localparam logic [2:0] FLAG_COPY_A        = 3'b010;
  localparam logic [2:0] FLAG_COPY_B        = 3'b011;
  localparam logic [2:0] FLAG_FIN_MIN_INF   = 3'b100;
  localparam logic [2:0] FLAG_ZERO_MIN_ZERO = 3'b101;
  localparam logic [2:0] FLAG_ZERO_MIN_SOME = 3'b110;
  localparam logic [2:0] FLAG_SUB_SAME_VAL  = 3'b111;

  typedef struct packed {
    logic [2:0]       flag;
    logic [WIDTH-2:0] operand;
    logic             a_sign;
    logic             b_sign;
    logic             op;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             accept;
  logic             zero_sign;
  entry_t           head;
  logic [WIDTH-1:0] resolved;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];
  assign accept = bus.out_valid && bus.out_ready;

  assign bus.exc_ready  = !full;
  assign bus.path_ready = !empty && (!bus.out_valid || bus.out_ready);

  assign push = bus.exc_valid && !full;
  assign pop  = bus.path_valid && bus.path_ready;

  // Signed-zero rule for x - x style results with both operands zero.
  assign zero_sign = head.op ? (head.a_sign & ~head.b_sign) : (head.a_sign & head.b_sign);

  always_comb begin
    resolved = bus.path_result;
    case (head.flag)
      FLAG_NONE:          resolved = bus.path_result;
      FLAG_NAN:           resolved = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};
      FLAG_COPY_A:        resolved = {head.a_sign, head.operand};
      FLAG_COPY_B:        resolved = {head.b_sign, head.operand};
      FLAG_FIN_MIN_INF:   resolved = {~head.b_sign, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
      FLAG_ZERO_MIN_ZERO: resolved = {zero_sign, {(WIDTH-1){1'b0}}};
      FLAG_ZERO_MIN_SOME: resolved = {~head.b_sign, head.operand};
      FLAG_SUB_SAME_VAL:  resolved = '0;
      default:            resolved = bus.path_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{flag:    bus.exception_flag,
                       operand: bus.copied_operand,
                       a_sign:  bus.a_sign,
                       b_sign:  bus.b_sign,
                       op:      bus.operation_select};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A pop in the accept cycle reloads the register directly, giving one result per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
    end else if (pop) begin
      bus.out_valid  <= 1'b1;
      bus.out_result <= resolved;
    end else if (accept) begin
      bus.out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.proto_err <= 1'b0;
    end else if (bus.path_valid && empty) begin
      bus.proto_err <= 1'b1;
    end
  end

`ifdef EXC_RESOLVER_STATUS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_flag  <= '0;
      bus.exc_count <= '0;
    end else if (pop) begin
      bus.out_flag <= head.flag;
      if (head.flag != FLAG_NONE && bus.exc_count != 16'hFFFF) begin
        bus.exc_count <= bus.exc_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exception_result_resolver.sv
// Directed and randomized bench for exception_result_resolver against a queue-based model.
module tb_exception_result_resolver;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0]  flag;
    logic [30:0] m;
    logic        a;
    logic        b;
    logic        op;
  } desc_t;

  logic clk;
  logic rst;

  exception_result_resolver_if #(.WIDTH(W)) bus ();

  exception_result_resolver #(
    .WIDTH(W), .EXP_BITS(8), .MANT_BITS(23), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  desc_t        mq[$];
  logic [W-1:0] exp_q[$];
  logic         m_ov;
  logic         m_perr;
  logic [2:0]   m_flag;
  int           m_cnt;
  int           n_total;
  int           n_pass;
  int           n_fail;

  function automatic logic [W-1:0] resolve(input desc_t d, input logic [W-1:0] path);
    logic s;
    case (d.flag)
      3'd0: return path;
      3'd1: return 32'h7FC00000;
      3'd2: return {d.a, d.m};
      3'd3: return {d.b, d.m};
      3'd4: return d.b ? 32'h7F800000 : 32'hFF800000;
      3'd5: begin
        s = d.op ? (d.a && !d.b) : (d.a && d.b);
        return s ? 32'h80000000 : 32'h00000000;
      end
      3'd6: return {~d.b, d.m};
      default: return 32'h00000000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic exc(input logic [2:0] f, input logic [30:0] m, input logic a,
                     input logic b, input logic op);
    bus.exc_valid        = 1'b1;
    bus.exception_flag   = f;
    bus.copied_operand   = m;
    bus.a_sign           = a;
    bus.b_sign           = b;
    bus.operation_select = op;
  endtask

  task automatic exc_rand();
    exc(3'($urandom_range(0, 7)), 31'($urandom), 1'($urandom_range(0, 1)),
        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic no_exc();
    bus.exc_valid = 1'b0;
  endtask

  // One clock: check DUT against the model, advance the model, cross the edge.
  task automatic step();
    logic  er, pr, do_push, do_pop;
    desc_t d;
    #1;
    er = (mq.size() < DEPTH);
    pr = (mq.size() != 0) && (!m_ov || bus.out_ready);
    check("exc_ready", W'(bus.exc_ready), W'(er));
    check("path_ready", W'(bus.path_ready), W'(pr));
    check("out_valid", W'(bus.out_valid), W'(m_ov));
    check("proto_err", W'(bus.proto_err), W'(m_perr));
    if (m_ov) check("out_result", bus.out_result, exp_q[0]);
`ifdef EXC_RESOLVER_STATUS_EN
    if (m_ov) check("out_flag", W'(bus.out_flag), W'(m_flag));
    check("exc_count", W'(bus.exc_count), W'(m_cnt));
`endif
    do_push = bus.exc_valid && er;
    do_pop  = bus.path_valid && pr;
    if (bus.path_valid && mq.size() == 0) m_perr = 1'b1;
    if (m_ov && bus.out_ready) begin
      void'(exp_q.pop_front());
      m_ov = 1'b0;
    end
    if (do_pop) begin
      d = mq.pop_front();
      exp_q.push_back(resolve(d, bus.path_result));
      m_ov   = 1'b1;
      m_flag = d.flag;
      if (d.flag != 3'd0 && m_cnt < 16'hFFFF) m_cnt++;
    end
    if (do_push) begin
      d.flag = bus.exception_flag;
      d.m    = bus.copied_operand;
      d.a    = bus.a_sign;
      d.b    = bus.b_sign;
      d.op   = bus.operation_select;
      mq.push_back(d);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.exc_valid  = 1'b0;
    bus.path_valid = 1'b0;
    bus.out_ready  = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    mq.delete();
    exp_q.delete();
    m_ov   = 1'b0;
    m_perr = 1'b0;
    m_flag = 3'd0;
    m_cnt  = 0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_valid"}, W'(bus.out_valid), '0);
    check({tag, "_out_result"}, bus.out_result, '0);
    check({tag, "_proto_err"}, W'(bus.proto_err), '0);
    check({tag, "_exc_ready"}, W'(bus.exc_ready), 32'd1);
    check({tag, "_path_ready"}, W'(bus.path_ready), '0);
  endtask

  // Bounded drain: keeps popping and accepting until the model is empty.
  task automatic drain();
    no_exc();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (mq.size() == 0 && !m_ov) break;
      bus.path_valid  = (mq.size() != 0);
      bus.path_result = $urandom;
      step();
    end
    bus.path_valid = 1'b0;
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1;
    bus.exc_valid = 1'b0; bus.exception_flag = '0; bus.copied_operand = '0;
    bus.a_sign = 1'b0; bus.b_sign = 1'b0; bus.operation_select = 1'b0;
    bus.path_valid = 1'b0; bus.path_result = '0; bus.out_ready = 1'b0;
    do_reset();
    do_reset();
    check_reset("rst0");

    // single NONE op passes the datapath result through
    bus.out_ready = 1'b1;
    exc(3'd0, 31'($urandom), 1'b0, 1'b1, 1'b0);
    step();
    no_exc();
    bus.path_valid = 1'b1; bus.path_result = 32'h40400000;
    step();
    bus.path_valid = 1'b0;
    check("t1_result", bus.out_result, 32'h40400000);
    check("t1_valid", W'(bus.out_valid), 32'd1);
    step();

    // NaN then finite-minus-inf, in order, at full throughput
    exc(3'd1, 31'($urandom), 1'b1, 1'b1, 1'b1);
    step();
    exc(3'd4, 31'($urandom), 1'b1, 1'b0, 1'b1);
    bus.path_valid = 1'b1; bus.path_result = $urandom;
    step();
    check("t2_nan", bus.out_result, 32'h7FC00000);
    no_exc();
    bus.path_result = $urandom;
    step();
    check("t2_inf", bus.out_result, 32'hFF800000);
    bus.path_valid = 1'b0;
    step();

    // copy and signed-zero cases
    exc(3'd2, 31'h3F800000, 1'b1, 1'b0, 1'b0); step();
    exc(3'd5, 31'($urandom), 1'b1, 1'b1, 1'b0); step();
    exc(3'd5, 31'($urandom), 1'b0, 1'b0, 1'b1); step();
    exc(3'd7, 31'($urandom), 1'b1, 1'b1, 1'b1); step();
    no_exc();
    bus.path_valid = 1'b1; bus.path_result = $urandom;
    step(); check("t3_copy_a", bus.out_result, 32'hBF800000);
    step(); check("t3_zz_add", bus.out_result, 32'h80000000);
    step(); check("t3_zz_sub", bus.out_result, 32'h00000000);
    step(); check("t3_same", bus.out_result, 32'h00000000);
    bus.path_valid = 1'b0;
    step();

    // fill to DEPTH, push against full, then one pop frees a slot
    for (int i = 0; i < DEPTH; i++) begin
      exc_rand();
      step();
    end
    check("t4_full", W'(bus.exc_ready), '0);
    exc_rand();
    step();
    no_exc();
    bus.path_valid = 1'b1; bus.path_result = $urandom;
    step();
    check("t4_ready", W'(bus.exc_ready), 32'd1);
    drain();

    // output stall: result holds, path_ready low, nothing lost
    for (int i = 0; i < 3; i++) begin
      exc_rand();
      step();
    end
    no_exc();
    bus.out_ready = 1'b0;
    bus.path_valid = 1'b1; bus.path_result = $urandom;
    step();
    for (int i = 0; i < 5; i++) begin
      check("t5_stall_pr", W'(bus.path_ready), '0);
      check("t5_stall_ov", W'(bus.out_valid), 32'd1);
      step();
    end
    drain();

    // protocol error is sticky, cleared only by reset
    bus.path_valid = 1'b1; bus.path_result = $urandom;
    step();
    bus.path_valid = 1'b0;
    step();
    step();
    check("t6_perr", W'(bus.proto_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      exc_rand();
      step();
    end
    no_exc();
    bus.out_ready = 1'b0;
    bus.path_valid = 1'b1;
    step();
    bus.path_valid = 1'b0;
    do_reset();
    check_reset("t6_rst");
    step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) exc_rand();
      else no_exc();
      if (mq.size() != 0) bus.path_valid = ($urandom_range(0, 3) != 0);
      else bus.path_valid = ($urandom_range(0, 19) == 0);
      bus.path_result = $urandom;
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    drain();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
